// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared memory-instruction class and LL/SC request types.
package sys_defs;

  localparam int LLSC_TAG_W = 6;

  typedef enum logic [2:0] {
    IS_NOP_INST   = 3'd0,
    IS_LD_INST    = 3'd1,
    IS_ST_INST    = 3'd2,
    IS_LDL_INST   = 3'd3,
    IS_STQ_INST   = 3'd4,
    IS_STQ_C_INST = 3'd5,
    IS_BR_INST    = 3'd6,
    IS_ALU_INST   = 3'd7
  } MEM_INST_TYPE;

  typedef struct packed {
    MEM_INST_TYPE          mem_type;
    logic [63:0]           addr;
    logic [LLSC_TAG_W-1:0] tag;
  } LLSC_REQ;

  // Only these classes touch the reservation table; everything else is dropped.
  function automatic logic is_llsc_relevant(input MEM_INST_TYPE t);
    case (t)
      IS_LD_INST, IS_STQ_INST, IS_LDL_INST, IS_STQ_C_INST: return 1'b1;
      default:                                             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/llsc_req_fifo.sv
// rtl/llsc_req_fifo.sv - in-order FIFO of LL/SC requests, two pushes and one pop per cycle.
module llsc_req_fifo
  import sys_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             wr0_en_i,
  input  LLSC_REQ          wr0_data_i,
  input  logic             wr1_en_i,
  input  LLSC_REQ          wr1_data_i,
  input  logic             rd_en_i,
  output LLSC_REQ          head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  LLSC_REQ          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr1_idx;

  // Port 1 lands behind port 0 when both push; DEPTH is a power of two so pointers wrap naturally.
  assign wr1_idx = wr_ptr_q + PTR_W'(wr0_en_i);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(wr0_en_i) + PTR_W'(wr1_en_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(rd_en_i);
    count_d  = count_q + CNT_W'(wr0_en_i) + CNT_W'(wr1_en_i) - CNT_W'(rd_en_i);
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr0_en_i) mem_q[wr_ptr_q] <= wr0_data_i;
    if (wr1_en_i) mem_q[wr1_idx]  <= wr1_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/llsc_port_arbiter.sv
// rtl/llsc_port_arbiter.sv - serialises two LSQ issue ports into the single-access LL/SC
// reservation table and returns store-conditional verdicts tagged with their ROB entry.
module llsc_port_arbiter
  import sys_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in0_valid,
  input  MEM_INST_TYPE     in0_type,
  input  logic [63:0]      in0_addr,
  input  logic [TAG_W-1:0] in0_tag,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  MEM_INST_TYPE     in1_type,
  input  logic [63:0]      in1_addr,
  input  logic [TAG_W-1:0] in1_tag,
  output logic             in1_ready,
  output logic             tbl_valid,
  output MEM_INST_TYPE     tbl_type,
  output logic [63:0]      tbl_addr,
  input  logic             tbl_sc_success,
  output logic             sc_result_valid,
  output logic [TAG_W-1:0] sc_result_tag,
  output logic             sc_success,
  output logic             full,
  output logic             empty
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  LLSC_REQ          req0, req1, head;
  logic [CNT_W-1:0] count, free;
  logic             push0, push1;

  logic             sc_valid_q, sc_valid_d;
  logic [TAG_W-1:0] sc_tag_q, sc_tag_d;
  logic             sc_succ_q, sc_succ_d;

  // Ready uses the current occupancy only; a same-cycle pop is never credited.
  assign free      = DEPTH_C - count;
  assign in0_ready = !flush && (free >= CNT_W'(1));
  assign in1_ready = !flush && (in0_valid ? (free >= CNT_W'(2)) : (free >= CNT_W'(1)));

  assign push0 = in0_valid && in0_ready && is_llsc_relevant(in0_type);
  assign push1 = in1_valid && in1_ready && is_llsc_relevant(in1_type);

  assign req0 = '{mem_type: in0_type, addr: in0_addr, tag: LLSC_TAG_W'(in0_tag)};
  assign req1 = '{mem_type: in1_type, addr: in1_addr, tag: LLSC_TAG_W'(in1_tag)};

  llsc_req_fifo #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_fifo (
    .clk_i     (clock),
    .rst_i     (reset),
    .clr_i     (flush),
    .wr0_en_i  (push0),
    .wr0_data_i(req0),
    .wr1_en_i  (push1),
    .wr1_data_i(req1),
    .rd_en_i   (tbl_valid),
    .head_o    (head),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign tbl_valid = !empty && !flush;
  assign tbl_type  = head.mem_type;
  assign tbl_addr  = head.addr;

  // Tag and verdict hold between results so the ROB can sample them lazily.
  always_comb begin
    sc_valid_d = tbl_valid && (head.mem_type == IS_STQ_C_INST);
    sc_tag_d   = sc_tag_q;
    sc_succ_d  = sc_succ_q;
    if (sc_valid_d) begin
      sc_tag_d  = TAG_W'(head.tag);
      sc_succ_d = tbl_sc_success;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sc_valid_q <= 1'b0;
      sc_tag_q   <= '0;
      sc_succ_q  <= 1'b0;
    end else begin
      sc_valid_q <= sc_valid_d;
      sc_tag_q   <= sc_tag_d;
      sc_succ_q  <= sc_succ_d;
    end
  end

  assign sc_result_valid = sc_valid_q;
  assign sc_result_tag   = sc_tag_q;
  assign sc_success      = sc_succ_q;

endmodule

// File: tb/tb_llsc_port_arbiter.sv
// tb/tb_llsc_port_arbiter.sv - self-checking bench for llsc_port_arbiter with a queue-based model.
module tb_llsc_port_arbiter;
  import sys_defs::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 6;

  logic               clock = 1'b0;
  logic               reset, flush;
  logic               in0_valid, in1_valid;
  MEM_INST_TYPE       in0_type, in1_type;
  logic [63:0]        in0_addr, in1_addr;
  logic [TAG_W-1:0]   in0_tag, in1_tag;
  logic               in0_ready, in1_ready;
  logic               tbl_valid;
  MEM_INST_TYPE       tbl_type;
  logic [63:0]        tbl_addr;
  logic               tbl_sc_success;
  logic               sc_result_valid;
  logic [TAG_W-1:0]   sc_result_tag;
  logic               sc_success;
  logic               full, empty;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  llsc_port_arbiter #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in0_valid(in0_valid), .in0_type(in0_type), .in0_addr(in0_addr), .in0_tag(in0_tag),
    .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_type(in1_type), .in1_addr(in1_addr), .in1_tag(in1_tag),
    .in1_ready(in1_ready),
    .tbl_valid(tbl_valid), .tbl_type(tbl_type), .tbl_addr(tbl_addr),
    .tbl_sc_success(tbl_sc_success),
    .sc_result_valid(sc_result_valid), .sc_result_tag(sc_result_tag), .sc_success(sc_success),
    .full(full), .empty(empty)
  );

  typedef struct {
    MEM_INST_TYPE     t;
    logic [63:0]      a;
    logic [TAG_W-1:0] g;
  } ent_t;

  ent_t             mq[$];
  ent_t             mh;
  logic             m_rv   = 1'b0;
  logic [TAG_W-1:0] m_tag  = '0;
  logic             m_succ = 1'b0;
  int               m_free;
  logic             m_r0, m_r1;

  function automatic logic relevant(input MEM_INST_TYPE t);
    return (t == IS_LD_INST) || (t == IS_STQ_INST) || (t == IS_LDL_INST) || (t == IS_STQ_C_INST);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a queue of accepted events, one pop per live cycle.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_rv   = 1'b0;
      m_tag  = '0;
      m_succ = 1'b0;
    end else begin
      m_free = DEPTH - mq.size();
      m_r0   = !flush && (m_free >= 1);
      m_r1   = !flush && (in0_valid ? (m_free >= 2) : (m_free >= 1));
      m_rv   = 1'b0;
      if (flush) begin
        mq.delete();
      end else begin
        if (mq.size() > 0) begin
          mh = mq.pop_front();
          if (mh.t == IS_STQ_C_INST) begin
            m_rv   = 1'b1;
            m_tag  = mh.g;
            m_succ = tbl_sc_success;
          end
        end
        if (in0_valid && m_r0 && relevant(in0_type)) mq.push_back('{in0_type, in0_addr, in0_tag});
        if (in1_valid && m_r1 && relevant(in1_type)) mq.push_back('{in1_type, in1_addr, in1_tag});
      end
    end
  end

  always @(negedge clock) begin
    int  sz;
    int  fr;
    logic ev;
    sz = mq.size();
    fr = DEPTH - sz;
    ev = (sz > 0) && !flush;
    chk("in0_ready", in0_ready, !flush && (fr >= 1));
    chk("in1_ready", in1_ready, !flush && (in0_valid ? (fr >= 2) : (fr >= 1)));
    chk("tbl_valid", tbl_valid, ev);
    if (ev) begin
      chk("tbl_type", tbl_type, mq[0].t);
      chk("tbl_addr", tbl_addr, mq[0].a);
    end
    chk("sc_result_valid", sc_result_valid, m_rv);
    chk("sc_result_tag", sc_result_tag, m_tag);
    chk("sc_success", sc_success, m_succ);
    chk("full", full, sz == DEPTH);
    chk("empty", empty, sz == 0);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in0_valid = 1'b0; in0_type = IS_NOP_INST; in0_addr = '0; in0_tag = '0;
    in1_valid = 1'b0; in1_type = IS_NOP_INST; in1_addr = '0; in1_tag = '0;
    flush = 1'b0;
  endtask

  task automatic drive0(input MEM_INST_TYPE t, input logic [63:0] a, input logic [TAG_W-1:0] g);
    in0_valid = 1'b1; in0_type = t; in0_addr = a; in0_tag = g;
  endtask

  task automatic drive1(input MEM_INST_TYPE t, input logic [63:0] a, input logic [TAG_W-1:0] g);
    in1_valid = 1'b1; in1_type = t; in1_addr = a; in1_tag = g;
  endtask

  initial begin
    reset = 1'b1;
    tbl_sc_success = 1'b0;
    idle();
    @(negedge clock);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_tbl_valid", tbl_valid, 0);
    chk("rst_in0_ready", in0_ready, 1);
    chk("rst_in1_ready", in1_ready, 1);
    chk("rst_sc_valid", sc_result_valid, 0);
    tick();
    reset = 1'b0;

    // LDL then STQ_C to the same line in one cycle
    drive0(IS_LDL_INST, 64'h100, 6'd3);
    drive1(IS_STQ_C_INST, 64'h100, 6'd4);
    @(negedge clock);
    chk("pair_in0_ready", in0_ready, 1);
    chk("pair_in1_ready", in1_ready, 1);
    tick(); idle(); tbl_sc_success = 1'b1;
    @(negedge clock);
    chk("pair_c1_valid", tbl_valid, 1);
    chk("pair_c1_type", tbl_type, IS_LDL_INST);
    chk("pair_c1_addr", tbl_addr, 64'h100);
    tick();
    @(negedge clock);
    chk("pair_c2_type", tbl_type, IS_STQ_C_INST);
    chk("pair_c2_scv", sc_result_valid, 0);
    tick();
    @(negedge clock);
    chk("pair_c3_scv", sc_result_valid, 1);
    chk("pair_c3_tag", sc_result_tag, 6'd4);
    chk("pair_c3_succ", sc_success, 1);
    chk("pair_c3_empty", empty, 1);
    tick();

    // Build occupancy to 3, then probe the two-slot rule and single-port-1 acceptance
    drive0(IS_LD_INST, 64'h1000, 6'd10); drive1(IS_LD_INST, 64'h1008, 6'd11);
    tick();
    drive0(IS_STQ_INST, 64'h1010, 6'd12); drive1(IS_STQ_INST, 64'h1018, 6'd13);
    tick();
    drive0(IS_LDL_INST, 64'h1020, 6'd14); drive1(IS_LD_INST, 64'h1028, 6'd15);
    @(negedge clock);
    chk("cnt3_in0_ready", in0_ready, 1);
    chk("cnt3_in1_ready", in1_ready, 0);
    tick(); idle();
    drive1(IS_STQ_INST, 64'h200, 6'd16);
    @(negedge clock);
    chk("solo1_in1_ready", in1_ready, 1);
    chk("solo1_full", full, 0);
    chk("solo1_empty", empty, 0);
    tick(); idle();
    @(negedge clock);
    chk("drain_addr0", tbl_addr, 64'h1018);
    tick();
    @(negedge clock);
    chk("drain_addr1", tbl_addr, 64'h1020);
    tick();
    @(negedge clock);
    chk("drain_addr2", tbl_addr, 64'h200);
    chk("drain_type2", tbl_type, IS_STQ_INST);
    tick();
    @(negedge clock);
    chk("drain_empty", empty, 1);
    chk("drain_tbl_valid", tbl_valid, 0);
    tick();

    // Flush during the STQ_C issue cycle
    drive0(IS_STQ_C_INST, 64'h300, 6'd9);
    tick(); idle(); flush = 1'b1;
    @(negedge clock);
    chk("flush_tbl_valid", tbl_valid, 0);
    chk("flush_in0_ready", in0_ready, 0);
    chk("flush_in1_ready", in1_ready, 0);
    tick(); flush = 1'b0;
    @(negedge clock);
    chk("flush_scv", sc_result_valid, 0);
    chk("flush_empty", empty, 1);
    tick();

    // Asynchronous reset with three entries queued and a result pending
    drive0(IS_STQ_C_INST, 64'h400, 6'd20); drive1(IS_LD_INST, 64'h408, 6'd21);
    tick();
    drive0(IS_LD_INST, 64'h410, 6'd22); drive1(IS_LD_INST, 64'h418, 6'd23);
    tick(); idle();
    chk("prerst_scv", sc_result_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_scv", sc_result_valid, 0);
    chk("arst_tbl_valid", tbl_valid, 0);
    tick(); reset = 1'b0;
    @(negedge clock);
    chk("postrst_tbl_valid", tbl_valid, 0);
    tick();

    for (int i = 0; i < 1500; i++) begin
      reset          = ($urandom_range(0, 149) == 0);
      flush          = ($urandom_range(0, 19) == 0);
      tbl_sc_success = $urandom_range(0, 1);
      in0_valid      = ($urandom_range(0, 3) != 0);
      in0_type       = MEM_INST_TYPE'($urandom_range(0, 7));
      in0_addr       = {$urandom, $urandom};
      in0_tag        = TAG_W'($urandom);
      in1_valid      = ($urandom_range(0, 3) != 0);
      in1_type       = MEM_INST_TYPE'($urandom_range(0, 7));
      in1_addr       = {$urandom, $urandom};
      in1_tag        = TAG_W'($urandom);
      tick();
    end
    reset = 1'b0;
    idle();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/llsc_port_arbiter.md
Name: llsc_port_arbiter

Overview:
- Serialises memory events from the two LSQ issue ports of the 2-way superscalar core into the single-access LL/SC reservation table.
- Buffers events in order in a small FIFO and drives one table access per cycle.
- Captures the table's store-conditional verdict and returns it to the ROB/LSQ with the originating ROB tag.
- Sits between the LSQ issue stage and the reservation table.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of two and at least 2.
- TAG_W, 6, ROB tag width.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; do not override).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  branch-mispredict squash.
- in0_valid  in  1  port 0 request. Port 0 is older in program order.
- in0_type  in  MEM_INST_TYPE  port 0 instruction class.
- in0_addr  in  64  port 0 effective address.
- in0_tag  in  TAG_W  port 0 ROB tag.
- in0_ready  out  1  port 0 accepted this cycle.
- in1_valid, in1_type, in1_addr, in1_tag, in1_ready: same as port 0, for port 1 (younger).
- tbl_valid  out  1  table access valid this cycle.
- tbl_type  out  MEM_INST_TYPE  class of the FIFO head.
- tbl_addr  out  64  address of the FIFO head.
- tbl_sc_success  in  1  table verdict for the current access; meaningful only when the access is IS_STQ_C_INST.
- sc_result_valid  out  1  store-conditional result valid.
- sc_result_tag  out  TAG_W  ROB tag of the resolved STQ_C.
- sc_success  out  1  1 = store succeeds, 0 = store fails.
- full  out  1  FIFO occupancy equals DEPTH.
- empty  out  1  FIFO occupancy equals 0.

Behaviour:
- Relevant classes are IS_LDL_INST, IS_STQ_C_INST, IS_LD_INST and IS_STQ_INST.
- Any other in*_type is accepted: in*_ready follows the normal rules, but the event is not enqueued.
- Acceptance, with free = DEPTH - count:
  - in0_ready = (free >= 1) && !flush.
  - in1_ready = !flush && (in0_valid ? free >= 2 : free >= 1).
  - Counting: when both ports present relevant events, free must be >= 2 before port 1 is ready.
  - Port 1 is never accepted unless port 0 is accepted or idle. This preserves program order.
- Enqueue order within a cycle: port 0 first, then port 1. A maximum of 2 pushes per cycle.
- Issue path (combinational from the FIFO head):
  - tbl_valid = !empty && !flush.
  - On every cycle with tbl_valid = 1, the head is popped at the clock edge. Dequeue is limited to 1 per cycle.
- Latency: minimum 1 cycle. An event accepted in cycle N appears at tbl_* in cycle N+1 at the earliest. There is no enqueue-to-table bypass.
- Simultaneous push and pop: count_next = count + pushes - pop.
  - The ready rules use the current count and never credit the same-cycle pop.
  - Pointers wrap modulo DEPTH.
- SC result:
  - When tbl_valid is set and tbl_type == IS_STQ_C_INST, the arbiter registers sc_result_valid = 1, sc_result_tag = head tag and sc_success = tbl_sc_success.
  - These are visible in cycle N+1 for one cycle.
  - In any other cycle sc_result_valid is 0.
  - sc_result_tag and sc_success hold their last value.
- Flush in cycle N:
  - No accepts and no table access in cycle N.
  - Pointers and count are cleared at the edge.
  - The sc_result_valid registered at that edge is 0.
  - The flush sequence lasts only one cycle; normal operation resumes in N+1.
- Reset (asynchronous): pointers, count, sc_result_valid, sc_result_tag and sc_success are set to 0.
  - Outputs under reset: empty = 1, full = 0, tbl_valid = 0, in*_ready = 1 (free = DEPTH).
  - A reset mid-operation discards all queued events and any pending result.
- Internal state machine: none beyond the FIFO counter. Occupancy is the state: EMPTY (count 0), PARTIAL, FULL (count DEPTH).

Decomposition:
- Shared package (sys_defs): MEM_INST_TYPE enum and a LLSC_REQ struct {MEM_INST_TYPE type; logic [63:0] addr; logic [TAG_W-1:0] tag}.
- One sub-module: llsc_req_fifo.
  - 2-push/1-pop in-order FIFO of LLSC_REQ, with async reset and synchronous clear.
  - Outputs: head, count, full, empty.
- The arbiter wrapper holds the ready logic, the type filter and the result register.

Test Plan:
- Reset, then in0 = LDL @0x100 tag 3 and in1 = STQ_C @0x100 tag 4 in the same cycle. Required: both ready; tbl shows LDL in cycle +1 and STQ_C in cycle +2.
  - With tbl_sc_success = 1: sc_result_valid = 1, tag = 4, success = 1 in cycle +3.
- DEPTH = 4 holding count 3, both ports valid. Required: in0_ready = 1, in1_ready = 0.
  - Next cycle, with one pop, count = 3 and full = 0.
- Fill the FIFO to 4 entries. Required: full = 1, both ready = 0.
  - Drain 4 cycles: tbl_type/tbl_addr appear in exact enqueue order; empty = 1 after cycle 4.
- Queue STQ_C tag 9 and assert flush in its issue cycle. Required: tbl_valid = 0, no sc_result_valid, count = 0 next cycle.
- in0 invalid, in1 = STQ @0x200. Required: in1_ready = 1 with count 3 of 4; entry issued next cycle.
- Assert reset asynchronously mid-burst with 3 entries queued. Required: empty = 1, sc_result_valid = 0 immediately, no table access until new input.
